ex_mc: RTL and testbench
========================

# ex_mc

Parametrised multi-cycle execute stage for the five-stage pipeline. It sits between the id_ex and ex_mem pipeline registers and supports logic, shift, add/subtract, compare, multiply and HI/LO-move operations. It also runs an iterative signed/unsigned divider that stalls the pipeline via `stallreq_o`. The architectural HI/LO registers live inside this block.

## Interface
- `DATA_W`, 32: operand/result width; must be even and ≥ 8.
- `ADDR_W`, 5: register-file write address width.
- `DIV_EN`, 1: 0 removes the divider; DIV/DIVU then give zero results, write nothing to HI/LO and raise no stall.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-low (`rst`=0 resets at the next rising edge).
- `aluop_i`  in  8  operation code (package constants).
- `alusel_i`  in  3  result class: LOGIC, SHIFT, ARITH, MOVE, NOP.
- `reg1_i`, `reg2_i`  in  DATA_W  source operands; `reg2_i` low log2(DATA_W) bits are the shift amount.
- `waddr_i`  in  ADDR_W  destination register.
- `we_i`  in  1  destination write enable.
- `flush_i`  in  1  abort any in-flight divide; no HI/LO write.
- `waddr_o`  out  ADDR_W  passthrough of `waddr_i`.
- `we_o`  out  1  passthrough of `we_i`.
- `wdata_o`  out  DATA_W  selected result.
- `stallreq_o`  out  1  high while a divide is incomplete.
- `hi_o`, `lo_o`  out  DATA_W  current HI/LO register contents.

## Operation
- Combinational results are ready in the same cycle:
  - LOGIC: OR, AND, XOR, NOR.
  - SHIFT: SLL, SRL, SRA.
  - ARITH: ADDU and SUBU wrap modulo 2^DATA_W. SLT is signed; SLTU is unsigned. Compare results are 1 or 0.
- `wdata_o` selected by `alusel_i`; unknown class or op gives 0.
- MOVE:
  - MFHI/MFLO put `hi_q`/`lo_q` on `wdata_o`.
  - MTHI/MTLO write `reg1_i` to HI/LO at the clock edge.
- MULT (signed) and MULTU (unsigned) form a 2·DATA_W product. Upper half goes to HI and lower half to LO at the edge. `wdata_o`=0.
- DIV (signed) and DIVU (unsigned) use a restoring, one-bit-per-cycle divider on absolute values.
  - Signed: quotient is negated when the operand signs differ; remainder takes the sign of the dividend.
  - LO ← quotient, HI ← remainder.
  - Divide by zero: HI=LO=0.
- Divider FSM:
  - IDLE → RUN on a DIV/DIVU op with divisor ≠ 0, loading operands and count=0.
  - IDLE → DZERO on a DIV/DIVU op with divisor = 0.
  - RUN: count increments each cycle; RUN → DONE when count = DATA_W−1.
  - DZERO → DONE.
  - DONE: HI/LO written at the edge; DONE → IDLE unconditionally. The same op still presented in DONE does not restart the divide.
- `stallreq_o` = DIV/DIVU presented AND state ≠ DONE. Upstream holds the inputs stable while it is high.
- Flush in any state, or reset in any state: next state IDLE, no HI/LO write.
- Reset values:
  - State IDLE, `hi_q`=`lo_q`=0.
  - While `rst`=0: `wdata_o`=0, `we_o`=0, `waddr_o`=0, `stallreq_o`=0.

## Timing
- Non-divide ops: 0-cycle combinational latency to `wdata_o`. HI/LO writes are visible on `hi_o`/`lo_o` the cycle after the op.
- Divide presented in cycle N, divisor ≠ 0:
  - `stallreq_o` high in cycles N … N+DATA_W.
  - Cycle N+DATA_W+1 is DONE with `stallreq_o` low.
  - HI/LO update at the end of DONE (DATA_W+2 cycles total).
- Divide by zero: stall in N, N+1; DONE in N+2.
- Back-to-back divides: the second divide enters IDLE in the cycle after DONE and starts normally.
- A MFHI immediately after DONE reads the new HI (no forwarding hazard inside the block).
- Flush has priority over DONE's HI/LO write. `rst` has priority over everything.

## Structure
- Shared package `ex_pkg`:
  - `aluop` codes: OR, AND, XOR, NOR, SLL, SRL, SRA, ADDU, SUBU, SLT, SLTU, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO, NOP.
  - `alusel` codes.
  - Divider state enum: IDLE, RUN, DZERO, DONE.
  - ZeroWord constant.
- One sub-module, `div_iter`:
  - Ports: `clk`, `rst`, `start`, `signed_op`, `abort`, dividend, divisor.
  - Outputs: `busy`, `done` (1-cycle), quotient, remainder.
  - Contains the FSM, counter and sign fix-up.
- HI/LO registers and the result mux stay in `ex_mc`.

## Test plan
- ORI-style OR: 0x0000_1100 | 0x0000_0011 with alusel LOGIC → `wdata_o`=0x0000_1111, `we_o`/`waddr_o` pass through in the same cycle.
- SRA 0x8000_0000 by 4 → 0xF800_0000. SLT −1 vs 1 → 1; SLTU 0xFFFF_FFFF vs 1 → 0.
- MULT 0xFFFF_FFFE (−2) × 3 → HI=0xFFFF_FFFF, LO=0xFFFF_FFFA on the next cycle. MFLO then returns 0xFFFF_FFFA.
- DIV −7 / 2 held stable → stall for 33 cycles, DONE at cycle 34, LO=0xFFFF_FFFD, HI=0xFFFF_FFFF. DIVU 7 / 0 → 2-cycle stall, HI=LO=0.
- DIVU 100/3 with `flush_i` at cycle 10 → IDLE next cycle, stall drops, HI/LO unchanged. A following DIVU 100/3 gives LO=33, HI=1.
- `rst`=0 asserted mid-divide after MTHI 0x1234 → next cycle HI=LO=0, `stallreq_o`=0, `wdata_o`=0.

Source files
------------

// File: rtl/ex_pkg.sv
// ex_pkg: shared definitions for the multi-cycle execute stage.
//   - aluop operation codes (8 bit) and alusel result classes (3 bit)
//   - divider FSM state type
//   - ZERO_WORD constant and a small decode helper
package ex_pkg;

  // Operation codes presented on aluop_i
  localparam logic [7:0] EXE_NOP   = 8'b0000_0000;
  localparam logic [7:0] EXE_OR    = 8'b0010_0101;
  localparam logic [7:0] EXE_AND   = 8'b0010_0100;
  localparam logic [7:0] EXE_XOR   = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR   = 8'b0010_0111;
  localparam logic [7:0] EXE_SLL   = 8'b0111_1100;
  localparam logic [7:0] EXE_SRL   = 8'b0000_0010;
  localparam logic [7:0] EXE_SRA   = 8'b0000_0011;
  localparam logic [7:0] EXE_ADDU  = 8'b0010_0001;
  localparam logic [7:0] EXE_SUBU  = 8'b0010_0011;
  localparam logic [7:0] EXE_SLT   = 8'b0010_1010;
  localparam logic [7:0] EXE_SLTU  = 8'b0010_1011;
  localparam logic [7:0] EXE_MULT  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU  = 8'b0001_1011;
  localparam logic [7:0] EXE_MFHI  = 8'b0001_0000;
  localparam logic [7:0] EXE_MTHI  = 8'b0001_0001;
  localparam logic [7:0] EXE_MFLO  = 8'b0001_0010;
  localparam logic [7:0] EXE_MTLO  = 8'b0001_0011;

  // Result classes presented on alusel_i
  localparam logic [2:0] SEL_NOP   = 3'b000;
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_MOVE  = 3'b011;
  localparam logic [2:0] SEL_ARITH = 3'b100;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    DIV_IDLE  = 2'd0,
    DIV_RUN   = 2'd1,
    DIV_DZERO = 2'd2,
    DIV_DONE  = 2'd3
  } div_state_e;

  function automatic logic is_div_op(input logic [7:0] op);
    return (op == EXE_DIV) || (op == EXE_DIVU);
  endfunction

endpackage

// File: rtl/ex_mc_div.sv
// div_iter: restoring one-bit-per-cycle divider working on absolute values,
// with sign fix-up of quotient (negated when operand signs differ) and
// remainder (sign of the dividend).
//   clk, rst     clock, synchronous active-low reset
//   start        DIV/DIVU presented; only acted on in IDLE
//   signed_op    1 = signed divide
//   abort        return to IDLE from any state
//   dividend     numerator, divisor: denominator
//   busy         divide requested and not yet in DONE (pipeline stall)
//   done         one-cycle DONE indication; quotient/remainder valid
//   quotient, remainder  signed-corrected results (0/0 on divide by zero)
module div_iter
  import ex_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              signed_op,
  input  logic              abort,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  localparam int CNT_W = $clog2(DATA_W);

  div_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] quo_q, rem_q, dvs_q;
  logic              q_neg_q, r_neg_q;

  logic              dvd_neg, dvs_neg, dvs_zero;
  logic [DATA_W-1:0] dvd_abs, dvs_abs;
  logic [DATA_W:0]   partial, diff;

  assign dvd_neg  = signed_op & dividend[DATA_W-1];
  assign dvs_neg  = signed_op & divisor[DATA_W-1];
  assign dvd_abs  = dvd_neg ? -dividend : dividend;
  assign dvs_abs  = dvs_neg ? -divisor : divisor;
  assign dvs_zero = (divisor == '0);

  // One restoring step: shift the next dividend bit into the partial
  // remainder and try to subtract. The MSB of diff is the borrow.
  assign partial = {rem_q, quo_q[DATA_W-1]};
  assign diff    = partial - {1'b0, dvs_q};

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_IDLE:  if (start) state_d = dvs_zero ? DIV_DZERO : DIV_RUN;
      DIV_RUN:   if (cnt_q == CNT_W'(DATA_W - 1)) state_d = DIV_DONE;
      DIV_DZERO: state_d = DIV_DONE;
      DIV_DONE:  state_d = DIV_IDLE;
      default:   state_d = DIV_IDLE;
    endcase
    if (abort) state_d = DIV_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample their inputs from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= DIV_IDLE;
    else      state_q <= state_d;
  end

  // NOTE: the datapath registers carry no reset; they are always loaded on
  // the IDLE->RUN/DZERO transition before anything reads them.
  always_ff @(posedge clk) begin
    if (state_q == DIV_IDLE && start) begin
      cnt_q   <= '0;
      dvs_q   <= dvs_abs;
      rem_q   <= '0;
      quo_q   <= dvs_zero ? '0 : dvd_abs;
      q_neg_q <= ~dvs_zero & (dvd_neg ^ dvs_neg);
      r_neg_q <= ~dvs_zero & dvd_neg;
    end else if (state_q == DIV_RUN) begin
      cnt_q <= cnt_q + CNT_W'(1);
      if (diff[DATA_W]) begin
        rem_q <= partial[DATA_W-1:0];
        quo_q <= {quo_q[DATA_W-2:0], 1'b0};
      end else begin
        rem_q <= diff[DATA_W-1:0];
        quo_q <= {quo_q[DATA_W-2:0], 1'b1};
      end
    end
  end

  assign busy      = start & (state_q != DIV_DONE);
  assign done      = (state_q == DIV_DONE);
  assign quotient  = q_neg_q ? -quo_q : quo_q;
  assign remainder = r_neg_q ? -rem_q : rem_q;

endmodule

// File: rtl/ex_mc.sv
// ex_mc: multi-cycle execute stage between id_ex and ex_mem. Logic, shift,
// add/sub and compare results are combinational; MULT/MULTU and MTHI/MTLO
// update the architectural HI/LO registers at the clock edge; DIV/DIVU run
// in the iterative divider and stall the pipeline until DONE.
//   clk, rst            clock, synchronous active-low reset
//   aluop_i, alusel_i   operation code and result class
//   reg1_i, reg2_i      operands (reg2_i low bits = shift amount)
//   waddr_i, we_i       destination, passed through to waddr_o, we_o
//   flush_i             abort in-flight divide, suppress HI/LO write
//   wdata_o             selected result
//   stallreq_o          divide presented and not yet complete
//   hi_o, lo_o          HI/LO register contents
module ex_mc
  import ex_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DIV_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        aluop_i,
  input  logic [2:0]        alusel_i,
  input  logic [DATA_W-1:0] reg1_i,
  input  logic [DATA_W-1:0] reg2_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic              we_i,
  input  logic              flush_i,
  output logic [ADDR_W-1:0] waddr_o,
  output logic              we_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              stallreq_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int SH_W = $clog2(DATA_W);

  logic [DATA_W-1:0]   hi_q, lo_q, hi_d, lo_d, result;
  logic [2*DATA_W-1:0] mul_s, mul_u;
  logic [SH_W-1:0]     shamt;
  logic                div_busy, div_done;
  logic [DATA_W-1:0]   div_quo, div_rem;

  assign shamt = reg2_i[SH_W-1:0];

  // Full-width products: sign- or zero-extend both operands to 2*DATA_W so
  // the low 2*DATA_W bits of the product are exact.
  assign mul_s = {{DATA_W{reg1_i[DATA_W-1]}}, reg1_i} * {{DATA_W{reg2_i[DATA_W-1]}}, reg2_i};
  assign mul_u = {{DATA_W{1'b0}}, reg1_i} * {{DATA_W{1'b0}}, reg2_i};

  generate
    if (DIV_EN != 0) begin : g_div
      div_iter #(.DATA_W(DATA_W)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (is_div_op(aluop_i)),
        .signed_op (aluop_i == EXE_DIV),
        .abort     (flush_i),
        .dividend  (reg1_i),
        .divisor   (reg2_i),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
      );
    end else begin : g_nodiv
      assign div_busy = 1'b0;
      assign div_done = 1'b0;
      assign div_quo  = '0;
      assign div_rem  = '0;
    end
  endgenerate

  always_comb begin
    result = DATA_W'(ZERO_WORD);
    case (alusel_i)
      SEL_LOGIC: begin
        case (aluop_i)
          EXE_OR:  result = reg1_i | reg2_i;
          EXE_AND: result = reg1_i & reg2_i;
          EXE_XOR: result = reg1_i ^ reg2_i;
          EXE_NOR: result = ~(reg1_i | reg2_i);
          default: ;
        endcase
      end
      SEL_SHIFT: begin
        case (aluop_i)
          EXE_SLL: result = reg1_i << shamt;
          EXE_SRL: result = reg1_i >> shamt;
          EXE_SRA: result = $signed(reg1_i) >>> shamt;
          default: ;
        endcase
      end
      SEL_ARITH: begin
        case (aluop_i)
          EXE_ADDU: result = reg1_i + reg2_i;
          EXE_SUBU: result = reg1_i - reg2_i;
          EXE_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(reg1_i) < $signed(reg2_i))};
          EXE_SLTU: result = {{(DATA_W-1){1'b0}}, (reg1_i < reg2_i)};
          default: ;
        endcase
      end
      SEL_MOVE: begin
        case (aluop_i)
          EXE_MFHI: result = hi_q;
          EXE_MFLO: result = lo_q;
          default: ;
        endcase
      end
      SEL_NOP: ;
      default: ;
    endcase
  end

  // HI/LO next value. A finished divide wins; otherwise the op decides.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (div_done) begin
      hi_d = div_rem;
      lo_d = div_quo;
    end else begin
      case (aluop_i)
        EXE_MULT:  {hi_d, lo_d} = mul_s;
        EXE_MULTU: {hi_d, lo_d} = mul_u;
        EXE_MTHI:  hi_d = reg1_i;
        EXE_MTLO:  lo_d = reg1_i;
        EXE_NOP:   ;
        default:   ;
      endcase
    end
  end

  // A flushed instruction must not commit anything to HI/LO.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (!flush_i) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  // Outputs are forced quiet while reset is held.
  assign wdata_o    = rst ? result : '0;
  assign we_o       = rst & we_i;
  assign waddr_o    = rst ? waddr_i : '0;
  assign stallreq_o = rst & div_busy;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule

// File: tb/tb_ex_mc.sv
// tb_ex_mc: self-checking bench for ex_mc (DATA_W=32). Inputs change on the
// falling edge and outputs are sampled 1 time unit later, away from the
// rising edge. A behavioural model (plain arithmetic) tracks HI/LO.
module tb_ex_mc;
  import ex_pkg::*;

  localparam int W = 32;
  localparam int AW = 5;
  localparam int DIV_LIMIT = 200;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    aluop;
  logic [2:0]    alusel;
  logic [W-1:0]  reg1, reg2;
  logic [AW-1:0] waddr;
  logic          we, flush;
  logic [AW-1:0] waddr_o;
  logic          we_o, stallreq_o;
  logic [W-1:0]  wdata_o, hi_o, lo_o;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] hi_m, lo_m;

  ex_mc #(.DATA_W(W), .ADDR_W(AW), .DIV_EN(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .aluop_i    (aluop),
    .alusel_i   (alusel),
    .reg1_i     (reg1),
    .reg2_i     (reg2),
    .waddr_i    (waddr),
    .we_i       (we),
    .flush_i    (flush),
    .waddr_o    (waddr_o),
    .we_o       (we_o),
    .wdata_o    (wdata_o),
    .stallreq_o (stallreq_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [7:0] op, input logic [2:0] sel,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    aluop = op; alusel = sel; reg1 = a; reg2 = b;
  endtask

  // Reference result computed from the architectural definitions.
  function automatic logic [W-1:0] model_alu(input logic [7:0] op, input logic [2:0] sel,
                                             input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb;
    int unsigned sh;
    sa = a; sb = b; sh = b % W;
    case (sel)
      SEL_LOGIC: case (op)
        EXE_OR:  return a | b;
        EXE_AND: return a & b;
        EXE_XOR: return a ^ b;
        EXE_NOR: return ~(a | b);
        default: return 32'd0;
      endcase
      SEL_SHIFT: case (op)
        EXE_SLL: return a << sh;
        EXE_SRL: return a >> sh;
        EXE_SRA: return sa >>> sh;
        default: return 32'd0;
      endcase
      SEL_ARITH: case (op)
        EXE_ADDU: return a + b;
        EXE_SUBU: return a - b;
        EXE_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
        EXE_SLTU: return (a < b) ? 32'd1 : 32'd0;
        default:  return 32'd0;
      endcase
      SEL_MOVE: case (op)
        EXE_MFHI: return hi_m;
        EXE_MFLO: return lo_m;
        default:  return 32'd0;
      endcase
      default: return 32'd0;
    endcase
  endfunction

  function automatic void model_div(input logic [7:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r);
    longint la, lb;
    if (b == 0) begin
      q = 0; r = 0;
    end else if (op == EXE_DIVU) begin
      q = a / b; r = a % b;
    end else begin
      la = $signed(a); lb = $signed(b);
      q = W'(la / lb); r = W'(la % lb);
    end
  endfunction

  // Present a divide and hold it until stallreq_o drops (DONE cycle).
  // Returns the stall cycle count and HI/LO seen at start and in DONE.
  task automatic run_div(input logic [7:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int stalls, output logic [W-1:0] hi_st, output logic [W-1:0] lo_st,
                         output logic [W-1:0] hi_dn, output logic [W-1:0] lo_dn);
    @(negedge clk);
    drive(op, SEL_NOP, a, b); we = 1'b0; flush = 1'b0;
    #1;
    hi_st = hi_o; lo_st = lo_o; stalls = 0;
    while (stallreq_o === 1'b1 && stalls < DIV_LIMIT) begin
      stalls++;
      @(negedge clk); #1;
    end
    hi_dn = hi_o; lo_dn = lo_o;
  endtask

  task automatic test_reset;
    rst = 1'b0; flush = 1'b0; we = 1'b1; waddr = 5'd5;
    drive(EXE_OR, SEL_LOGIC, 32'h0000_00FF, 32'h0000_0F00);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (wdata_o !== 32'd0) begin errors++; $display("FAIL reset_wdata got %h want 0", wdata_o); end
    checks++; if (we_o !== 1'b0 || waddr_o !== 5'd0) begin errors++; $display("FAIL reset_we_waddr got %b/%0d want 0/0", we_o, waddr_o); end
    checks++; if (hi_o !== 32'd0 || lo_o !== 32'd0) begin errors++; $display("FAIL reset_hilo got %h/%h want 0/0", hi_o, lo_o); end
    drive(EXE_DIV, SEL_NOP, 32'd7, 32'd2); #1;
    checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stallreq_o); end
    @(negedge clk);
    rst = 1'b1; we = 1'b0; waddr = '0; drive(EXE_NOP, SEL_NOP, 0, 0);
    hi_m = 0; lo_m = 0;
  endtask

  task automatic test_logic;
    logic [7:0] ops [4] = '{EXE_OR, EXE_AND, EXE_XOR, EXE_NOR};
    logic [W-1:0] exp;
    @(negedge clk);
    we = 1'b1; waddr = 5'd3; drive(EXE_OR, SEL_LOGIC, 32'h0000_1100, 32'h0000_0011); #1;
    checks++; if (wdata_o !== 32'h0000_1111) begin errors++; $display("FAIL ori got %h want 00001111", wdata_o); end
    checks++; if (we_o !== 1'b1 || waddr_o !== 5'd3) begin errors++; $display("FAIL ori_pass got %b/%0d want 1/3", we_o, waddr_o); end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      we = 1'($urandom_range(0, 1)); waddr = AW'($urandom);
      drive(ops[$urandom_range(0, 3)], SEL_LOGIC, $urandom, $urandom); #1;
      exp = model_alu(aluop, alusel, reg1, reg2);
      checks++;
      if ({we_o, waddr_o, wdata_o} !== {we, waddr, exp}) begin
        errors++; $display("FAIL logic_rand op %h got %b/%0d/%h want %b/%0d/%h", aluop, we_o, waddr_o, wdata_o, we, waddr, exp);
      end
    end
    we = 1'b0;
  endtask

  task automatic test_shift;
    logic [7:0] ops [3] = '{EXE_SLL, EXE_SRL, EXE_SRA};
    logic [W-1:0] exp;
    @(negedge clk);
    drive(EXE_SRA, SEL_SHIFT, 32'h8000_0000, 32'd4); #1;
    checks++; if (wdata_o !== 32'hF800_0000) begin errors++; $display("FAIL sra got %h want f8000000", wdata_o); end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(ops[$urandom_range(0, 2)], SEL_SHIFT, $urandom, $urandom); #1;
      exp = model_alu(aluop, alusel, reg1, reg2);
      checks++; if (wdata_o !== exp) begin errors++; $display("FAIL shift_rand op %h a %h b %h got %h want %h", aluop, reg1, reg2, wdata_o, exp); end
    end
  endtask

  task automatic test_arith;
    logic [7:0] ops [4] = '{EXE_ADDU, EXE_SUBU, EXE_SLT, EXE_SLTU};
    logic [W-1:0] exp;
    @(negedge clk);
    drive(EXE_SLT, SEL_ARITH, 32'hFFFF_FFFF, 32'd1); #1;
    checks++; if (wdata_o !== 32'd1) begin errors++; $display("FAIL slt got %h want 1", wdata_o); end
    drive(EXE_SLTU, SEL_ARITH, 32'hFFFF_FFFF, 32'd1); #1;
    checks++; if (wdata_o !== 32'd0) begin errors++; $display("FAIL sltu got %h want 0", wdata_o); end
    drive(EXE_ADDU, SEL_ARITH, 32'hFFFF_FFFF, 32'd2); #1;
    checks++; if (wdata_o !== 32'd1) begin errors++; $display("FAIL addu_wrap got %h want 1", wdata_o); end
    drive(EXE_ADDU, SEL_LOGIC, 32'h1234, 32'h1); #1;
    checks++; if (wdata_o !== 32'd0) begin errors++; $display("FAIL bad_op got %h want 0", wdata_o); end
    drive(EXE_OR, 3'b111, 32'h1234, 32'h1); #1;
    checks++; if (wdata_o !== 32'd0) begin errors++; $display("FAIL bad_sel got %h want 0", wdata_o); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(ops[$urandom_range(0, 3)], SEL_ARITH, $urandom, $urandom);
      if ($urandom_range(0, 3) == 0) reg2 = reg1 ^ 32'h8000_0000;
      #1;
      exp = model_alu(aluop, alusel, reg1, reg2);
      checks++; if (wdata_o !== exp) begin errors++; $display("FAIL arith_rand op %h a %h b %h got %h want %h", aluop, reg1, reg2, wdata_o, exp); end
    end
  endtask

  task automatic test_mult;
    logic [7:0] ops [6] = '{EXE_MULT, EXE_MULTU, EXE_MTHI, EXE_MTLO, EXE_MFHI, EXE_MFLO};
    longint p;
    longint unsigned pu;
    logic [W-1:0] exp;
    @(negedge clk);
    drive(EXE_MULT, SEL_NOP, 32'hFFFF_FFFE, 32'd3); #1;
    checks++; if (wdata_o !== 32'd0) begin errors++; $display("FAIL mult_wdata got %h want 0", wdata_o); end
    @(negedge clk);
    drive(EXE_MFLO, SEL_MOVE, 0, 0); #1;
    hi_m = 32'hFFFF_FFFF; lo_m = 32'hFFFF_FFFA;
    checks++; if (hi_o !== hi_m || lo_o !== lo_m) begin errors++; $display("FAIL mult_hilo got %h/%h want %h/%h", hi_o, lo_o, hi_m, lo_m); end
    checks++; if (wdata_o !== lo_m) begin errors++; $display("FAIL mflo got %h want %h", wdata_o, lo_m); end
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      drive(ops[$urandom_range(0, 5)], SEL_NOP, $urandom, $urandom);
      if (aluop == EXE_MTHI || aluop == EXE_MTLO || aluop == EXE_MFHI || aluop == EXE_MFLO) alusel = SEL_MOVE;
      #1;
      checks++; if (hi_o !== hi_m || lo_o !== lo_m) begin errors++; $display("FAIL hilo_rand got %h/%h want %h/%h", hi_o, lo_o, hi_m, lo_m); end
      exp = model_alu(aluop, alusel, reg1, reg2);
      checks++; if (wdata_o !== exp) begin errors++; $display("FAIL move_rand op %h got %h want %h", aluop, wdata_o, exp); end
      case (aluop)
        EXE_MULT:  begin p = longint'($signed(reg1)) * longint'($signed(reg2)); {hi_m, lo_m} = p; end
        EXE_MULTU: begin pu = {32'd0, reg1} * {32'd0, reg2}; {hi_m, lo_m} = pu; end
        EXE_MTHI:  hi_m = reg1;
        EXE_MTLO:  lo_m = reg1;
        default: ;
      endcase
    end
    @(negedge clk);
    drive(EXE_NOP, SEL_NOP, 0, 0); #1;
    checks++; if (hi_o !== hi_m || lo_o !== lo_m) begin errors++; $display("FAIL hilo_final got %h/%h want %h/%h", hi_o, lo_o, hi_m, lo_m); end
  endtask

  task automatic test_div;
    logic [7:0]   op_t [8];
    logic [W-1:0] a_t [8], b_t [8];
    logic [W-1:0] q, r, hs, ls, hd, ld;
    int stalls, exp_st;
    op_t[0] = EXE_DIV;  a_t[0] = 32'hFFFF_FFF9; b_t[0] = 32'd2;
    op_t[1] = EXE_DIVU; a_t[1] = 32'd7;         b_t[1] = 32'd0;
    op_t[2] = EXE_DIV;  a_t[2] = 32'h8000_0000; b_t[2] = 32'hFFFF_FFFF;
    op_t[3] = EXE_DIV;  a_t[3] = 32'd100;       b_t[3] = 32'hFFFF_FFF9;
    for (int i = 4; i < 8; i++) begin
      op_t[i] = ($urandom_range(0, 1) != 0) ? EXE_DIV : EXE_DIVU;
      a_t[i] = $urandom;
      b_t[i] = ($urandom >> $urandom_range(0, 30)) | 32'd1;
      if ($urandom_range(0, 1) != 0) b_t[i] = -b_t[i];
    end
    for (int i = 0; i < 8; i++) begin
      run_div(op_t[i], a_t[i], b_t[i], stalls, hs, ls, hd, ld);
      exp_st = (b_t[i] == 0) ? 2 : W + 1;
      checks++; if (stalls !== exp_st) begin errors++; $display("FAIL div_stall #%0d got %0d want %0d", i, stalls, exp_st); end
      checks++; if (hd !== hi_m || ld !== lo_m) begin errors++; $display("FAIL div_done_hilo #%0d got %h/%h want %h/%h", i, hd, ld, hi_m, lo_m); end
      model_div(op_t[i], a_t[i], b_t[i], q, r);
      hi_m = r; lo_m = q;
      @(negedge clk);
      drive(EXE_MFHI, SEL_MOVE, 0, 0); #1;
      checks++; if (hi_o !== hi_m || lo_o !== lo_m) begin errors++; $display("FAIL div_result #%0d a %h b %h got %h/%h want %h/%h", i, a_t[i], b_t[i], hi_o, lo_o, hi_m, lo_m); end
      checks++; if (wdata_o !== hi_m) begin errors++; $display("FAIL mfhi_after_div #%0d got %h want %h", i, wdata_o, hi_m); end
    end
  endtask

  task automatic test_flush;
    logic [W-1:0] hs, ls, hd, ld;
    int stalls;
    @(negedge clk);
    drive(EXE_DIVU, SEL_NOP, 32'd100, 32'd3);
    repeat (10) @(negedge clk);
    flush = 1'b1; #1;
    checks++; if (stallreq_o !== 1'b1) begin errors++; $display("FAIL flush_cycle_stall got %b want 1", stallreq_o); end
    @(negedge clk);
    flush = 1'b0; drive(EXE_NOP, SEL_NOP, 0, 0); #1;
    checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL flush_stall got %b want 0", stallreq_o); end
    repeat (40) @(negedge clk);
    #1;
    checks++; if (hi_o !== hi_m || lo_o !== lo_m) begin errors++; $display("FAIL flush_hilo got %h/%h want %h/%h", hi_o, lo_o, hi_m, lo_m); end
    run_div(EXE_DIVU, 32'd100, 32'd3, stalls, hs, ls, hd, ld);
    checks++; if (stalls !== W + 1) begin errors++; $display("FAIL after_flush_stall got %0d want %0d", stalls, W + 1); end
    @(negedge clk);
    drive(EXE_NOP, SEL_NOP, 0, 0); #1;
    hi_m = 32'd1; lo_m = 32'd33;
    checks++; if (hi_o !== hi_m || lo_o !== lo_m) begin errors++; $display("FAIL after_flush_div got %h/%h want 1/21", hi_o, lo_o); end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] a1, b1, a2, b2, q1, r1, q2, r2, hs, ls, hd, ld;
    int s1, s2;
    a1 = $urandom; b1 = ($urandom >> 8) | 32'd1;
    a2 = $urandom; b2 = -(($urandom >> 16) | 32'd1);
    model_div(EXE_DIVU, a1, b1, q1, r1);
    model_div(EXE_DIV, a2, b2, q2, r2);
    run_div(EXE_DIVU, a1, b1, s1, hs, ls, hd, ld);
    run_div(EXE_DIV, a2, b2, s2, hs, ls, hd, ld);
    checks++; if (s1 !== W + 1 || s2 !== W + 1) begin errors++; $display("FAIL b2b_stalls got %0d/%0d want %0d/%0d", s1, s2, W + 1, W + 1); end
    checks++; if (hs !== r1 || ls !== q1) begin errors++; $display("FAIL b2b_first got %h/%h want %h/%h", hs, ls, r1, q1); end
    @(negedge clk);
    drive(EXE_NOP, SEL_NOP, 0, 0); #1;
    hi_m = r2; lo_m = q2;
    checks++; if (hi_o !== hi_m || lo_o !== lo_m) begin errors++; $display("FAIL b2b_second got %h/%h want %h/%h", hi_o, lo_o, hi_m, lo_m); end
  endtask

  task automatic test_reset_mid_div;
    logic [W-1:0] hs, ls, hd, ld;
    int stalls;
    @(negedge clk);
    drive(EXE_MTHI, SEL_MOVE, 32'h1234, 0);
    @(negedge clk);
    we = 1'b1; waddr = 5'd9; drive(EXE_DIV, SEL_NOP, 32'd100, 32'd7); #1;
    checks++; if (hi_o !== 32'h1234) begin errors++; $display("FAIL mthi got %h want 1234", hi_o); end
    repeat (5) @(negedge clk);
    rst = 1'b0; #1;
    checks++; if (stallreq_o !== 1'b0 || we_o !== 1'b0 || waddr_o !== 5'd0 || wdata_o !== 32'd0) begin
      errors++; $display("FAIL rst_outputs got %b/%b/%0d/%h want 0/0/0/0", stallreq_o, we_o, waddr_o, wdata_o);
    end
    @(negedge clk);
    rst = 1'b1; we = 1'b0; waddr = '0; drive(EXE_NOP, SEL_NOP, 0, 0); #1;
    hi_m = 0; lo_m = 0;
    checks++; if (hi_o !== 32'd0 || lo_o !== 32'd0 || stallreq_o !== 1'b0 || wdata_o !== 32'd0) begin
      errors++; $display("FAIL rst_mid_div got %h/%h/%b/%h want 0/0/0/0", hi_o, lo_o, stallreq_o, wdata_o);
    end
    run_div(EXE_DIVU, 32'd100, 32'd7, stalls, hs, ls, hd, ld);
    checks++; if (stalls !== W + 1) begin errors++; $display("FAIL post_rst_stall got %0d want %0d", stalls, W + 1); end
    @(negedge clk);
    drive(EXE_NOP, SEL_NOP, 0, 0); #1;
    hi_m = 32'd2; lo_m = 32'd14;
    checks++; if (hi_o !== hi_m || lo_o !== lo_m) begin errors++; $display("FAIL post_rst_div got %h/%h want %h/%h", hi_o, lo_o, hi_m, lo_m); end
  endtask

  initial begin
    test_reset();
    test_logic();
    test_shift();
    test_arith();
    test_mult();
    test_div();
    test_flush();
    test_back_to_back();
    test_reset_mid_div();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
